cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 130 +++++++++++++
 tb/tb_cache_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-port arbiter sharing one memory request channel between an I-cache and a D-cache,
// with a bounded-starvation policy that favours D until I has waited STARVE_MAX grants.
module cache_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 4,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              arb_busy,
    output logic [2:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_DONE = 3'd3,
        D_DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_req;
    logic             d_wins;

    // Handshake: requests are level-sensitive and only sampled in IDLE; the memory op is
    // held stable until mem_resp, and completion is a single-cycle x_resp pulse in X_DONE.
    assign d_req  = d_read | d_write;
    assign d_wins = d_req && (!i_read || (starve_cnt < CNT_W'(STARVE_MAX)));

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            i_resp     <= 1'b0;
            i_rdata    <= '0;
            d_resp     <= 1'b0;
            d_rdata    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            arb_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state    <= D_BUSY;
                        arb_busy <= 1'b1;
                        mem_addr <= d_addr;
                        // A simultaneous read+write request is treated as a writeback.
                        if (d_write) begin
                            mem_write <= 1'b1;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_read <= 1'b1;
                        end
                        if (!i_read) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt < CNT_W'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (i_read) begin
                        state      <= I_BUSY;
                        arb_busy   <= 1'b1;
                        mem_addr   <= i_addr;
                        mem_read   <= 1'b1;
                        starve_cnt <= '0;
                    end
                end
                I_BUSY: begin
                    if (mem_resp) begin
                        state    <= I_DONE;
                        i_rdata  <= mem_rdata;
                        i_resp   <= 1'b1;
                        mem_read <= 1'b0;
                    end
                end
                D_BUSY: begin
                    if (mem_resp) begin
                        state <= D_DONE;
                        if (mem_read) begin
                            d_rdata <= mem_rdata;
                        end
                        d_resp    <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                I_DONE: begin
                    state    <= IDLE;
                    i_resp   <= 1'b0;
                    arb_busy <= 1'b0;
                end
                D_DONE: begin
                    state    <= IDLE;
                    d_resp   <= 1'b0;
                    arb_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a memory responder, a stimulus driver and a
// response monitor checking completions against an expected queue.
module tb_cache_arbiter;

    localparam int ADDR_W     = 16;
    localparam int LINE_W     = 128;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_I_BUSY = 3'd1;
    localparam logic [2:0] S_D_BUSY = 3'd2;
    localparam logic [2:0] S_I_DONE = 3'd3;
    localparam logic [2:0] S_D_DONE = 3'd4;

    localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_5A = {16{8'h5A}};

    logic              clk;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              arb_busy;
    logic [2:0]        dbg_state;
    logic [CNT_W-1:0]  dbg_starve_cnt;

    // Memory model controls
    int                mem_lat;
    logic              use_fixed;
    logic [LINE_W-1:0] fixed_data;
    logic              spurious;
    int                busy_cnt;

    logic [LINE_W:0]   exp_q[$];
    int                n_cmp;
    int                n_err;

    cache_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W:0] act, input logic [LINE_W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [LINE_W-1:0] data);
        exp_q.push_back({is_d, data});
    endtask

    task automatic pop_check(input logic is_d, input logic [LINE_W-1:0] data);
        logic [LINE_W:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got %s resp data %h, expected none", is_d ? "d" : "i", data);
        end else begin
            e = exp_q.pop_front();
            chk(is_d ? "d_resp_data" : "i_resp_data", {is_d, data}, e);
        end
    endtask

    // Memory responder: answers after mem_lat BUSY cycles, or fakes mem_resp when idle
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            busy_cnt  = busy_cnt + 1;
            mem_resp  = (busy_cnt >= mem_lat);
            mem_rdata = use_fixed ? fixed_data : {8{mem_addr}};
        end else begin
            busy_cnt = 0;
            mem_resp = spurious;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read || mem_write) chk("mem_exclusive", {{LINE_W{1'b0}}, mem_read & mem_write}, '0);
            if (i_resp) pop_check(1'b0, i_rdata);
            if (d_resp) pop_check(1'b1, d_rdata);
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(dbg_state == S_IDLE && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {{LINE_W{1'b0}}, n >= budget}, '0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        mem_lat = 1; use_fixed = 1'b1; fixed_data = '0; spurious = 1'b0; busy_cnt = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctl", {{(LINE_W-6){1'b0}}, mem_read, mem_write, i_resp, d_resp, arb_busy, 1'b0}, '0);
        chk("rst_state", {{(LINE_W-2){1'b0}}, dbg_state}, '0);
        chk("rst_starve", {{(LINE_W+1-CNT_W){1'b0}}, dbg_starve_cnt}, '0);
        chk("rst_i_rdata", {1'b0, i_rdata}, '0);
        chk("rst_d_rdata", {1'b0, d_rdata}, '0);
        chk("rst_mem_addr", {{(LINE_W+1-ADDR_W){1'b0}}, mem_addr}, '0);
        chk("rst_mem_wdata", {1'b0, mem_wdata}, '0);
        rst_n = 1'b1;

        // I read alone, 3-cycle memory
        @(negedge clk);
        mem_lat = 3; use_fixed = 1'b1; fixed_data = PAT_A5;
        i_read = 1'b1; i_addr = 16'h1230;
        push_exp(1'b0, PAT_A5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_read = 1'b0;
            chk("i_mem_read", {{(LINE_W-1){1'b0}}, mem_read, mem_write}, 2'b10);
            chk("i_mem_addr", {{(LINE_W+1-ADDR_W){1'b0}}, mem_addr}, {{(LINE_W+1-ADDR_W){1'b0}}, 16'h1230});
            chk("i_busy", {{LINE_W{1'b0}}, arb_busy}, 1);
        end
        @(negedge clk);
        chk("i_done_state", {{(LINE_W-2){1'b0}}, dbg_state}, {{(LINE_W-2){1'b0}}, S_I_DONE});
        chk("i_mem_released", {{(LINE_W-1){1'b0}}, mem_read, mem_write}, '0);
        @(negedge clk);
        chk("i_back_idle", {{(LINE_W-2){1'b0}}, dbg_state}, {{(LINE_W-2){1'b0}}, S_IDLE});
        chk("i_resp_pulse", {{LINE_W{1'b0}}, i_resp}, '0);
        chk("i_rdata_hold", {1'b0, i_rdata}, {1'b0, PAT_A5});
        wait_idle(20);

        // D write with both d_read and d_write set
        mem_lat = 1;
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h4000; d_wdata = PAT_5A;
        push_exp(1'b1, '0);
        @(negedge clk);
        d_read = 1'b0; d_write = 1'b0;
        chk("d_wr_ctl", {{(LINE_W-1){1'b0}}, mem_read, mem_write}, 2'b01);
        chk("d_wr_addr", {{(LINE_W+1-ADDR_W){1'b0}}, mem_addr}, {{(LINE_W+1-ADDR_W){1'b0}}, 16'h4000});
        chk("d_wr_wdata", {1'b0, mem_wdata}, {1'b0, PAT_5A});
        @(negedge clk);
        chk("d_done_state", {{(LINE_W-2){1'b0}}, dbg_state}, {{(LINE_W-2){1'b0}}, S_D_DONE});
        chk("i_rdata_untouched", {1'b0, i_rdata}, {1'b0, PAT_A5});
        wait_idle(20);

        // Simultaneous requests: D wins STARVE_MAX times, then I
        use_fixed = 1'b0;
        i_read = 1'b1; i_addr = 16'h0100;
        d_read = 1'b1; d_addr = 16'h0200;
        for (int g = 0; g < STARVE_MAX; g++) push_exp(1'b1, {8{16'h0200}});
        push_exp(1'b0, {8{16'h0100}});
        begin
            int n_d = 0;
            int n = 0;
            while (!i_resp && n < 80) begin
                @(negedge clk);
                n++;
                if (d_resp) begin
                    n_d++;
                    if (n_d == STARVE_MAX)
                        chk("starve_full", {{(LINE_W+1-CNT_W){1'b0}}, dbg_starve_cnt},
                            {{(LINE_W+1-CNT_W){1'b0}}, CNT_W'(STARVE_MAX)});
                end
            end
            chk("starve_timeout", {{LINE_W{1'b0}}, n >= 80}, '0);
            chk("starve_d_count", n_d, STARVE_MAX);
        end
        i_read = 1'b0; d_read = 1'b0;
        wait_idle(20);
        chk("starve_cleared", {{(LINE_W+1-CNT_W){1'b0}}, dbg_starve_cnt}, '0);

        // Reset mid D_BUSY, with an I request held across it
        mem_lat = 5; use_fixed = 1'b1; fixed_data = PAT_5A;
        d_read = 1'b1; d_addr = 16'h0300;
        @(negedge clk);
        d_read = 1'b0;
        i_read = 1'b1; i_addr = 16'h0440;
        chk("rm_d_busy", {{(LINE_W-2){1'b0}}, dbg_state}, {{(LINE_W-2){1'b0}}, S_D_BUSY});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_ctl", {{(LINE_W-6){1'b0}}, mem_read, mem_write, i_resp, d_resp, arb_busy, 1'b0}, '0);
        chk("rm_state", {{(LINE_W-2){1'b0}}, dbg_state}, '0);
        chk("rm_mem_addr", {{(LINE_W+1-ADDR_W){1'b0}}, mem_addr}, '0);
        chk("rm_i_rdata", {1'b0, i_rdata}, '0);
        chk("rm_d_rdata", {1'b0, d_rdata}, '0);
        repeat (2) @(negedge clk);
        mem_lat = 2; use_fixed = 1'b0;
        rst_n = 1'b1;
        push_exp(1'b0, {8{16'h0440}});
        @(negedge clk);
        i_read = 1'b0;
        chk("rm_i_grant", {{(LINE_W-2){1'b0}}, dbg_state}, {{(LINE_W-2){1'b0}}, S_I_BUSY});
        chk("rm_i_addr", {{(LINE_W+1-ADDR_W){1'b0}}, mem_addr}, {{(LINE_W+1-ADDR_W){1'b0}}, 16'h0440});
        wait_idle(20);

        // Spurious mem_resp while idle
        spurious = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("sp_idle", {{(LINE_W-2){1'b0}}, dbg_state}, {{(LINE_W-2){1'b0}}, S_IDLE});
        end
        spurious = 1'b0;
        @(negedge clk);
        chk("sp_i_rdata", {1'b0, i_rdata}, {1'b0, {8{16'h0440}}});
        chk("sp_d_rdata", {1'b0, d_rdata}, '0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
